// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR burst arbiter: FSM encodings and slot numbering.
package ddr_arb_pkg;

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    // Slot numbering; bit 1 set means a read slot, bit 0 selects the channel.
    localparam logic [1:0] SLOT_WR0 = 2'd0;
    localparam logic [1:0] SLOT_WR1 = 2'd1;
    localparam logic [1:0] SLOT_RD0 = 2'd2;
    localparam logic [1:0] SLOT_RD1 = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-slot round-robin picker. The slot after ptr has the highest
// priority; gnt is one-hot (all zero when nothing is requested).
module rr_arbiter4 import ddr_arb_pkg::*; (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_SLOTS-1:0] gnt,
    output logic [1:0]           idx
);

    logic [1:0] slot;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        slot = '0;
        for (int i = NUM_SLOTS; i >= 1; i--) begin
            slot = ptr + 2'(i);
            if (req[slot]) begin
                gnt       = '0;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Shares the memory controller burst port between two write and two read
// channels, one whole burst at a time.
// Optional build macro WR_PRIORITY_EN: pending writes beat reads, with
// separate round-robin inside the write pair and the read pair. Without it a
// flat 4-slot round-robin is used.
module ddr_burst_arbiter import ddr_arb_pkg::*; #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10
) (
    input  logic                       mem_clk,
    input  logic                       rst,
    input  logic [1:0]                 wr_req,
    input  logic [2*BURST_BITS-1:0]    wr_len,
    input  logic [2*ADDR_BITS-1:0]     wr_addr,
    input  logic [2*MEM_DATA_BITS-1:0] wr_data,
    output logic [1:0]                 wr_data_req,
    output logic [1:0]                 wr_finish,
    input  logic [1:0]                 rd_req,
    input  logic [2*BURST_BITS-1:0]    rd_len,
    input  logic [2*ADDR_BITS-1:0]     rd_addr,
    output logic [1:0]                 rd_data_valid,
    output logic [1:0]                 rd_finish,
    output logic [MEM_DATA_BITS-1:0]   rd_data,
    output logic                       mem_wr_burst_req,
    output logic [BURST_BITS-1:0]      mem_wr_burst_len,
    output logic [ADDR_BITS-1:0]       mem_wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]   mem_wr_burst_data,
    input  logic                       mem_wr_burst_data_req,
    input  logic                       mem_wr_burst_finish,
    output logic                       mem_rd_burst_req,
    output logic [BURST_BITS-1:0]      mem_rd_burst_len,
    output logic [ADDR_BITS-1:0]       mem_rd_burst_addr,
    input  logic [MEM_DATA_BITS-1:0]   mem_rd_burst_data,
    input  logic                       mem_rd_burst_data_valid,
    input  logic                       mem_rd_burst_finish,
    output logic                       busy,
    output logic [1:0]                 grant_idx
);

    arb_state_t state, state_nxt;

    logic [NUM_SLOTS-1:0] req4;
    logic [1:0]           win_idx;
    logic                 win_vld;
    logic                 do_grant, do_issue, do_clear;
    logic                 fin_match, first_data, burst_done;
    logic                 wr_sel, rd_sel;

    assign req4 = {rd_req, wr_req};

`ifdef WR_PRIORITY_EN
    logic                 wr_ptr, rd_ptr;
    logic [NUM_SLOTS-1:0] wr_gnt, rd_gnt;
    logic [1:0]           wr_idx, rd_idx;

    rr_arbiter4 u_wr_arb (
        .req ({2'b00, req4[1:0]}),
        .ptr ({1'b0, wr_ptr}),
        .gnt (wr_gnt),
        .idx (wr_idx)
    );

    rr_arbiter4 u_rd_arb (
        .req ({2'b00, req4[3:2]}),
        .ptr ({1'b0, rd_ptr}),
        .gnt (rd_gnt),
        .idx (rd_idx)
    );

    // Any pending write wins; otherwise the read pair's choice, mapped to slots 2/3.
    always_comb begin
        win_vld = (|wr_gnt) | (|rd_gnt);
        win_idx = (|wr_gnt) ? wr_idx : (rd_idx | SLOT_RD0);
    end

    // Per-pair pointers advance to the slot that just completed.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b1;
            rd_ptr <= 1'b1;
        end else if (burst_done) begin
            if (grant_idx[1]) rd_ptr <= grant_idx[0];
            else              wr_ptr <= grant_idx[0];
        end
    end
`else
    logic [1:0]           rr_ptr;
    logic [NUM_SLOTS-1:0] gnt;

    rr_arbiter4 u_arb (
        .req (req4),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign win_vld = |gnt;

    // Pointer starts at the last slot so slot 0 wins first after reset.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)             rr_ptr <= SLOT_RD1;
        else if (burst_done) rr_ptr <= grant_idx;
    end
`endif

    // Only the granted direction's strobes matter; the other side is ignored.
    assign fin_match  = grant_idx[1] ? mem_rd_burst_finish     : mem_wr_burst_finish;
    assign first_data = grant_idx[1] ? mem_rd_burst_data_valid : mem_wr_burst_data_req;
    assign burst_done = (state == S_BUSY) && fin_match;

    // FSM state register.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and datapath control strobes.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_issue  = 1'b0;
        do_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    do_grant  = 1'b1;
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                do_issue  = 1'b1;
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // A length-1 burst can finish on its first beat; clear and leave together.
                if (first_data || fin_match) do_clear = 1'b1;
                if (fin_match) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, burst descriptor and request registers driven by the FSM strobes.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            grant_idx         <= '0;
            busy              <= 1'b0;
            mem_wr_burst_req  <= 1'b0;
            mem_rd_burst_req  <= 1'b0;
            mem_wr_burst_len  <= '0;
            mem_wr_burst_addr <= '0;
            mem_rd_burst_len  <= '0;
            mem_rd_burst_addr <= '0;
        end else begin
            if (do_grant) begin
                grant_idx <= win_idx;
                busy      <= 1'b1;
                if (win_idx[1]) begin
                    mem_rd_burst_len  <= win_idx[0] ? rd_len[2*BURST_BITS-1:BURST_BITS] : rd_len[BURST_BITS-1:0];
                    mem_rd_burst_addr <= win_idx[0] ? rd_addr[2*ADDR_BITS-1:ADDR_BITS]  : rd_addr[ADDR_BITS-1:0];
                end else begin
                    mem_wr_burst_len  <= win_idx[0] ? wr_len[2*BURST_BITS-1:BURST_BITS] : wr_len[BURST_BITS-1:0];
                    mem_wr_burst_addr <= win_idx[0] ? wr_addr[2*ADDR_BITS-1:ADDR_BITS]  : wr_addr[ADDR_BITS-1:0];
                end
            end
            if (do_issue) begin
                if (grant_idx[1]) mem_rd_burst_req <= 1'b1;
                else              mem_wr_burst_req <= 1'b1;
            end
            if (do_clear) begin
                mem_wr_burst_req <= 1'b0;
                mem_rd_burst_req <= 1'b0;
            end
            // busy drops as the burst completes, so it is already low in S_DONE.
            if (burst_done) busy <= 1'b0;
        end
    end

    assign wr_sel = busy && !grant_idx[1];
    assign rd_sel = busy &&  grant_idx[1];

    // Route controller strobes to the granted channel only.
    always_comb begin
        wr_data_req   = 2'b00;
        wr_finish     = 2'b00;
        rd_data_valid = 2'b00;
        rd_finish     = 2'b00;
        if (wr_sel) begin
            wr_data_req[grant_idx[0]] = mem_wr_burst_data_req;
            wr_finish[grant_idx[0]]   = mem_wr_burst_finish;
        end
        if (rd_sel) begin
            rd_data_valid[grant_idx[0]] = mem_rd_burst_data_valid;
            rd_finish[grant_idx[0]]     = mem_rd_burst_finish;
        end
    end

    assign mem_wr_burst_data = grant_idx[0] ? wr_data[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                            : wr_data[MEM_DATA_BITS-1:0];
    assign rd_data = mem_rd_burst_data;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter: stimulus queues expected grants,
// a monitor checks each grant, the routing of every controller strobe, and
// request/busy behaviour around data and finish.
module tb_ddr_burst_arbiter;

    localparam int DW = 32;
    localparam int AW = 23;
    localparam int BW = 10;
    localparam logic [DW-1:0] WD0 = 32'hA5A5_0000;
    localparam logic [DW-1:0] WD1 = 32'h5A5A_0001;

    typedef struct {
        logic [1:0]    slot;
        logic [BW-1:0] len;
        logic [AW-1:0] addr;
    } exp_t;

    logic            mem_clk, rst;
    logic [1:0]      wr_req, rd_req;
    logic [2*BW-1:0] wr_len, rd_len;
    logic [2*AW-1:0] wr_addr, rd_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      wr_data_req, wr_finish, rd_data_valid, rd_finish;
    logic [DW-1:0]   rd_data;
    logic            mem_wr_burst_req, mem_rd_burst_req;
    logic [BW-1:0]   mem_wr_burst_len, mem_rd_burst_len;
    logic [AW-1:0]   mem_wr_burst_addr, mem_rd_burst_addr;
    logic [DW-1:0]   mem_wr_burst_data, mem_rd_burst_data;
    logic            mem_wr_burst_data_req, mem_wr_burst_finish;
    logic            mem_rd_burst_data_valid, mem_rd_burst_finish;
    logic            busy;
    logic [1:0]      grant_idx;

    exp_t exp_q[$];
    int   tests = 0;
    int   errs  = 0;
    int   fin_cnt = 0;
    logic stray_arm;
    logic stray_done = 1'b0;

    ddr_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BW)) dut (
        .mem_clk(mem_clk), .rst(rst),
        .wr_req(wr_req), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_data_req(wr_data_req), .wr_finish(wr_finish),
        .rd_req(rd_req), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_finish(rd_finish), .rd_data(rd_data),
        .mem_wr_burst_req(mem_wr_burst_req), .mem_wr_burst_len(mem_wr_burst_len),
        .mem_wr_burst_addr(mem_wr_burst_addr), .mem_wr_burst_data(mem_wr_burst_data),
        .mem_wr_burst_data_req(mem_wr_burst_data_req), .mem_wr_burst_finish(mem_wr_burst_finish),
        .mem_rd_burst_req(mem_rd_burst_req), .mem_rd_burst_len(mem_rd_burst_len),
        .mem_rd_burst_addr(mem_rd_burst_addr), .mem_rd_burst_data(mem_rd_burst_data),
        .mem_rd_burst_data_valid(mem_rd_burst_data_valid), .mem_rd_burst_finish(mem_rd_burst_finish),
        .busy(busy), .grant_idx(grant_idx)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: one gap cycle after the request, then len beats with
    // finish on the last beat, then one cooldown cycle. Optionally fires a
    // single stray read finish during the gap of a write burst.
    logic c_act, c_gap, c_wr;
    int   c_left;
    always @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            c_act <= 1'b0; c_gap <= 1'b0; c_wr <= 1'b0; c_left <= 0;
            mem_wr_burst_data_req   <= 1'b0; mem_wr_burst_finish <= 1'b0;
            mem_rd_burst_data_valid <= 1'b0; mem_rd_burst_finish <= 1'b0;
            mem_rd_burst_data       <= '0;
        end else begin
            mem_wr_burst_data_req   <= 1'b0; mem_wr_burst_finish <= 1'b0;
            mem_rd_burst_data_valid <= 1'b0; mem_rd_burst_finish <= 1'b0;
            if (!c_act) begin
                if (mem_wr_burst_req || mem_rd_burst_req) begin
                    c_act  <= 1'b1;
                    c_gap  <= 1'b1;
                    c_wr   <= mem_wr_burst_req;
                    c_left <= mem_wr_burst_req ? int'(mem_wr_burst_len) : int'(mem_rd_burst_len);
                end
            end else if (c_gap) begin
                c_gap <= 1'b0;
                if (c_wr && stray_arm && !stray_done) begin
                    mem_rd_burst_finish <= 1'b1;
                    stray_done          <= 1'b1;
                end
            end else if (c_left == 0) begin
                c_act <= 1'b0;
            end else begin
                if (c_wr) mem_wr_burst_data_req <= 1'b1;
                else begin
                    mem_rd_burst_data_valid <= 1'b1;
                    mem_rd_burst_data       <= 32'hD000_0000 | 32'(c_left);
                end
                if (c_left == 1) begin
                    if (c_wr) mem_wr_burst_finish <= 1'b1;
                    else      mem_rd_burst_finish <= 1'b1;
                end
                c_left <= c_left - 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every new burst request and checks routing.
    initial begin
        logic [1:0] cur_slot;
        logic prev_req, prev_strobe, prev_fin, cur_req;
        exp_t e;
        cur_slot = 2'd0; prev_req = 1'b0; prev_strobe = 1'b0; prev_fin = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (rst) begin
                prev_req = 1'b0; prev_strobe = 1'b0; prev_fin = 1'b0;
            end else begin
                cur_req = mem_wr_burst_req | mem_rd_burst_req;
                if (cur_req && !prev_req) begin
                    if (exp_q.size() == 0) check("unexpected_grant", {62'd0, grant_idx}, 64'hFF);
                    else begin
                        e = exp_q.pop_front();
                        cur_slot = e.slot;
                        check("grant_slot", {60'd0, grant_idx, mem_rd_burst_req, mem_wr_burst_req},
                              {60'd0, e.slot, e.slot[1], ~e.slot[1]});
                        if (e.slot[1]) check("rd_len_addr", {mem_rd_burst_len, mem_rd_burst_addr}, {e.len, e.addr});
                        else           check("wr_len_addr", {mem_wr_burst_len, mem_wr_burst_addr}, {e.len, e.addr});
                    end
                end
                if (prev_strobe) check("req_clear_after_data", {63'd0, cur_req}, 64'd0);
                if (prev_fin)    check("busy_after_finish", {62'd0, busy, cur_req}, 64'd0);
                if (mem_wr_burst_data_req | mem_wr_burst_finish | mem_rd_burst_data_valid | mem_rd_burst_finish) begin
                    logic [1:0] ewr, ewf, erv, erf;
                    ewr = 2'b00; ewf = 2'b00; erv = 2'b00; erf = 2'b00;
                    if (!cur_slot[1]) begin
                        ewr[cur_slot[0]] = mem_wr_burst_data_req;
                        ewf[cur_slot[0]] = mem_wr_burst_finish;
                    end else begin
                        erv[cur_slot[0]] = mem_rd_burst_data_valid;
                        erf[cur_slot[0]] = mem_rd_burst_finish;
                    end
                    check("routing", {56'd0, wr_data_req, wr_finish, rd_data_valid, rd_finish},
                          {56'd0, ewr, ewf, erv, erf});
                end
                if (mem_wr_burst_data_req)   check("wr_data_mux", {32'd0, mem_wr_burst_data}, {32'd0, cur_slot[0] ? WD1 : WD0});
                if (mem_rd_burst_data_valid) check("rd_data_bcast", {32'd0, rd_data}, {32'd0, mem_rd_burst_data});
                prev_req    = cur_req;
                prev_strobe = (|wr_data_req) | (|rd_data_valid);
                prev_fin    = (|wr_finish) | (|rd_finish);
                if (prev_fin) fin_cnt++;
            end
        end
    end

    task automatic push_exp(input logic [1:0] s, input logic [BW-1:0] l, input logic [AW-1:0] a);
        exp_t e;
        e.slot = s; e.len = l; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic set_slot(input int s, input logic [BW-1:0] l, input logic [AW-1:0] a);
        if (s < 2) begin
            wr_len[s*BW +: BW]  = l;
            wr_addr[s*AW +: AW] = a;
        end else begin
            rd_len[(s-2)*BW +: BW]  = l;
            rd_addr[(s-2)*AW +: AW] = a;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
        repeat (2) @(negedge mem_clk);
        rst = 1'b0;
        @(negedge mem_clk);
    endtask

    task automatic wait_strobe(input int s);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge mem_clk);
            seen = (s < 2) ? wr_data_req[s] : rd_data_valid[s-2];
        end
        check($sformatf("strobe_seen_slot%0d", s), {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_fin(input int target);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge mem_clk);
            seen = (fin_cnt >= target);
        end
        check("finish_seen", {63'd0, seen}, 64'd1);
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        stray_arm = 1'b0;
        wr_len = '0; wr_addr = '0; rd_len = '0; rd_addr = '0;
        wr_data = {WD1, WD0};

        // Single write burst: reset state, 2-cycle latency, one finish.
        do_reset();
        check("reset_state", {11'd0, busy, grant_idx, mem_wr_burst_req, mem_rd_burst_req,
                              mem_wr_burst_len, mem_wr_burst_addr}, 64'd0);
        set_slot(0, 10'd16, 23'h000100);
        push_exp(2'd0, 10'd16, 23'h000100);
        n = fin_cnt;
        wr_req[0] = 1'b1;
        @(negedge mem_clk);
        check("grant_lat_cycle1", {62'd0, busy, mem_wr_burst_req}, 64'd2);
        @(negedge mem_clk);
        check("grant_lat_cycle2", {63'd0, mem_wr_burst_req}, 64'd1);
        wait_strobe(0);
        wr_req[0] = 1'b0;
        wait_fin(n + 1);
        repeat (4) @(negedge mem_clk);
        check("wr0_finish_once", 64'(fin_cnt - n), 64'd1);

        // All four requesting: strict 0,1,2,3 rotation.
        do_reset();
        set_slot(0, 10'd2, 23'h000010);
        set_slot(1, 10'd3, 23'h000020);
        set_slot(2, 10'd2, 23'h000030);
        set_slot(3, 10'd1, 23'h000040);
        for (int k = 0; k < 8; k++) begin
            case (k % 4)
                0: push_exp(2'd0, 10'd2, 23'h000010);
                1: push_exp(2'd1, 10'd3, 23'h000020);
                2: push_exp(2'd2, 10'd2, 23'h000030);
                default: push_exp(2'd3, 10'd1, 23'h000040);
            endcase
        end
        n = fin_cnt;
        wr_req = 2'b11; rd_req = 2'b11;
        wait_fin(n + 8);
        wr_req = 2'b00; rd_req = 2'b00;
        repeat (6) @(negedge mem_clk);
        check("rotation_queue_drained", 64'(exp_q.size()), 64'd0);
        check("rotation_finish_count", 64'(fin_cnt - n), 64'd8);

        // Length-1 read at top address: finish with the only data beat.
        do_reset();
        set_slot(3, 10'd1, 23'h7FFFF0);
        push_exp(2'd3, 10'd1, 23'h7FFFF0);
        n = fin_cnt;
        rd_req[1] = 1'b1;
        wait_strobe(3);
        rd_req[1] = 1'b0;
        check("len1_finish_with_valid", {62'd0, rd_finish}, 64'd2);
        @(negedge mem_clk);
        check("len1_done_next", {61'd0, busy, rd_finish}, 64'd0);
        repeat (4) @(negedge mem_clk);
        check("len1_finish_once", 64'(fin_cnt - n), 64'd1);

        // Stray read finish during a write burst is ignored.
        do_reset();
        set_slot(0, 10'd4, 23'h000200);
        push_exp(2'd0, 10'd4, 23'h000200);
        n = fin_cnt;
        stray_arm = 1'b1;
        wr_req[0] = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge mem_clk);
                seen = stray_done;
            end
            check("stray_fired", {63'd0, seen}, 64'd1);
        end
        check("stray_rd_finish_blocked", {62'd0, rd_finish}, 64'd0);
        @(negedge mem_clk);
        check("stray_no_state_change", {62'd0, busy, mem_wr_burst_req}, 64'd3);
        wait_strobe(0);
        wr_req[0] = 1'b0;
        wait_fin(n + 1);
        stray_arm = 1'b0;
        repeat (4) @(negedge mem_clk);

        // Reset mid-burst, then wr1 wins over rd0 because slot 0 is idle.
        do_reset();
        set_slot(0, 10'd16, 23'h000300);
        push_exp(2'd0, 10'd16, 23'h000300);
        wr_req[0] = 1'b1;
        wait_strobe(0);
        wr_req[0] = 1'b0;
        repeat (3) @(negedge mem_clk);
        rst = 1'b1;
        #1;
        check("reset_mid_busy", {18'd0, busy, grant_idx, mem_wr_burst_req, mem_rd_burst_req,
                                 wr_data_req, wr_finish, rd_data_valid, rd_finish,
                                 mem_wr_burst_len, mem_wr_burst_addr}, 64'd0);
        set_slot(1, 10'd2, 23'h000400);
        set_slot(2, 10'd3, 23'h000500);
        push_exp(2'd1, 10'd2, 23'h000400);
        push_exp(2'd2, 10'd3, 23'h000500);
        wr_req = 2'b10; rd_req = 2'b01;
        @(negedge mem_clk);
        rst = 1'b0;
        n = fin_cnt;
        wait_strobe(1);
        wr_req[1] = 1'b0;
        wait_strobe(2);
        rd_req[0] = 1'b0;
        wait_fin(n + 2);
        repeat (4) @(negedge mem_clk);

`ifdef WR_PRIORITY_EN
        // Writes keep precedence over a waiting read.
        do_reset();
        set_slot(0, 10'd2, 23'h000600);
        set_slot(1, 10'd2, 23'h000610);
        set_slot(2, 10'd2, 23'h000620);
        push_exp(2'd1, 10'd2, 23'h000610);
        n = fin_cnt;
        rd_req[0] = 1'b1; wr_req[1] = 1'b1;
        wait_strobe(1);
        wr_req = 2'b01;
        push_exp(2'd0, 10'd2, 23'h000600);
        wait_strobe(0);
        wr_req = 2'b00;
        push_exp(2'd2, 10'd2, 23'h000620);
        wait_strobe(2);
        rd_req[0] = 1'b0;
        wait_fin(n + 3);
        repeat (4) @(negedge mem_clk);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
Shares the single burst interface of the external memory controller between two frame write channels and two frame read channels. Each channel uses the native burst handshake (req/len/addr, data_valid or data_req, finish). The arbiter grants one whole burst at a time, round-robin across the four slots, and holds the grant until mem finish. It sits between the frame FIFO read/write controllers and the DDR3 user interface, all in mem_clk.

Parameters:
MEM_DATA_BITS, 32, data width of the burst data bus
ADDR_BITS, 23, burst address width
BURST_BITS, 10, burst length width

Ports:
mem_clk  in  1  memory controller user clock
rst  in  1  asynchronous active-high reset
wr_req  in  2  per-write-channel burst request, held until first wr_data_req
wr_len  in  2*BURST_BITS  packed burst lengths, ch0 in LSBs
wr_addr  in  2*ADDR_BITS  packed burst addresses
wr_data  in  2*MEM_DATA_BITS  packed write data
wr_data_req  out  2  routed mem_wr_burst_data_req
wr_finish  out  2  routed mem_wr_burst_finish
rd_req  in  2  per-read-channel burst request, held until first rd_data_valid
rd_len  in  2*BURST_BITS  packed lengths
rd_addr  in  2*ADDR_BITS  packed addresses
rd_data_valid  out  2  routed mem_rd_burst_data_valid
rd_finish  out  2  routed mem_rd_burst_finish
rd_data  out  MEM_DATA_BITS  broadcast of mem_rd_burst_data
mem_wr_burst_req / _len / _addr  out  1/BURST_BITS/ADDR_BITS  to controller
mem_wr_burst_data  out  MEM_DATA_BITS  muxed write data
mem_wr_burst_data_req, mem_wr_burst_finish  in  1 each
mem_rd_burst_req / _len / _addr  out  1/BURST_BITS/ADDR_BITS  to controller
mem_rd_burst_data  in  MEM_DATA_BITS
mem_rd_burst_data_valid, mem_rd_burst_finish  in  1 each
busy  out  1  a burst is granted
grant_idx  out  2  slot of current/last grant: 0=wr0, 1=wr1, 2=rd0, 3=rd1

Behaviour:
- Reset is asynchronous on rst and clears everything: every registered output goes to 0, state=S_IDLE, rr_ptr=3, so slot 0 has first priority after reset.
- Request vector is req4={rd_req[1],rd_req[0],wr_req[1],wr_req[0]}.
- S_IDLE:
  - If req4 is nonzero, the winner is the first set slot scanning rr_ptr+1, rr_ptr+2, ... mod 4.
  - Register grant_idx, and latch len/addr of the winning slot into mem_*_burst_len/addr. Set busy=1 and go to S_GRANT.
- S_GRANT: assert mem_wr_burst_req (slots 0-1) or mem_rd_burst_req (slots 2-3). Go to S_BUSY. Grant latency from req to mem req is 2 cycles.
- S_BUSY:
  - Hold mem req until the first mem_wr_burst_data_req or mem_rd_burst_data_valid, then clear it.
  - Routing is combinational to the granted slot only; all other slots see 0:
    - wr_data_req[g] = mem_wr_burst_data_req
    - rd_data_valid[g] = mem_rd_burst_data_valid
    - wr_finish/rd_finish[g] = matching mem finish
  - mem_wr_burst_data = wr_data slice of grant_idx (combinational mux, valid in every state).
  - On matching mem finish: rr_ptr<=grant_idx, go to S_DONE.
- S_DONE: one idle cycle so the finished channel can lower req. busy=0, go to S_IDLE. grant_idx keeps its value.
- Boundary conditions:
  - Finish in the same cycle as the first data_valid (length-1 burst): clear req and go to S_DONE together.
  - Finish on the non-granted direction (rd vs wr) is ignored.
  - A requester dropping req before it is granted is simply not granted.
  - A request arriving mid-burst waits.
  - len=0 is passed through unchanged; completion depends on the controller.
- rd_data is always a broadcast; channels qualify it with their own rd_data_valid.
- No slot starves: with all four requesting, the grant order is 0,1,2,3,0,...

Optional Feature:
WR_PRIORITY_EN: when defined, the arbiter uses two-level priority. Any pending write slot beats every read slot. Round-robin still applies within the write pair and within the read pair, using separate 1-bit pointers. When not defined, a flat 4-slot round-robin applies as above.

Decomposition:
- Shared package (ddr_arb_pkg): state encodings S_IDLE=0, S_GRANT=1, S_BUSY=2, S_DONE=3; slot constants SLOT_WR0..SLOT_RD1; NUM_SLOTS=4.
- One natural sub-module: rr_arbiter4 (combinational, request vector plus pointer in, one-hot plus index out). It is instantiated once in flat mode, and as two 2-way instances plus priority logic when WR_PRIORITY_EN is defined.

Test Plan:
- After reset, wr_req[0]=1 with addr 0x000100 and len 16. Expect mem_wr_burst_req high 2 cycles later with addr 0x000100 and len 16; req clears on the first data_req; wr_finish[0] pulses once; busy falls 1 cycle after finish.
- All four requests held continuously for 8 bursts. Expect grant_idx sequence 0,1,2,3,0,1,2,3, and only the granted slot sees data_valid/data_req.
- rd_req[1] only, rd_addr slice = 0x7FFFF0, len 1, with data_valid and finish in the same cycle. Expect S_DONE next cycle, and rd_finish[1]=1 for exactly 1 cycle.
- Stray mem_rd_burst_finish during a granted write burst. Expect no state change and rd_finish=0; the write completes normally.
- Assert rst mid-S_BUSY. Expect all outputs 0 immediately; after release, a pending wr_req[1] and rd_req[0] are granted wr1 first (rr_ptr=3 after reset, so slot 0 has top priority; slot 0 is not requesting, so slot 1 wins).
- With WR_PRIORITY_EN defined: rd_req[0] and wr_req[1] pending together. Expect grant to wr1. Repeated write requests then keep precedence over the read until no write is pending.
